// File: rtl/axis_pkg_deserializer_if.sv
// Bundles the AXI4-Stream slave beat side and the package handoff side of the
// package deserializer; the slave modport is the deserializer's view.
interface axis_pkg_deserializer_if #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int PACKAGE_WIDTH        = 1600
);
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata;
    logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb;
    logic                              s_axis_tlast;
    logic                              s_axis_tvalid;
    logic                              s_axis_tready;
    logic [PACKAGE_WIDTH-1:0]          pkg_data_o;
    logic                              pkg_valid_o;
    logic                              pkg_ready_i;
    logic                              pkg_last_err_o;
    logic                              short_err_o;

    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tlast, s_axis_tvalid, pkg_ready_i,
        input  s_axis_tready, pkg_data_o, pkg_valid_o, pkg_last_err_o, short_err_o
    );

    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tlast, s_axis_tvalid, pkg_ready_i,
        output s_axis_tready, pkg_data_o, pkg_valid_o, pkg_last_err_o, short_err_o
    );
endinterface

// File: rtl/axis_pkg_deserializer.sv
// Collects NUM stream beats into one wide package (beat 0 in the LSBs), holds it
// until the consumer takes it, and drops short packages or drains overlong ones.
module axis_pkg_deserializer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int NUM                  = 50,
    parameter int PACKAGE_WIDTH        = 1600
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    axis_pkg_deserializer_if.slave bus
);
    localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM - 1);

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DRAIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [PACKAGE_WIDTH-1:0] r_data;
    logic                     r_pkg_valid;
    logic                     r_last_err;
    logic                     r_short_err;
    logic                     w_tready;
    logic                     w_xfer;
    logic                     w_pkg_hs;
    logic                     w_unused_tstrb;

    // tready depends on the registered state only, never on pkg_ready_i.
    assign w_tready       = (r_state != HOLD);
    assign w_xfer         = bus.s_axis_tvalid && w_tready;
    assign w_pkg_hs       = r_pkg_valid && bus.pkg_ready_i;
    assign w_unused_tstrb = ^bus.s_axis_tstrb;

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= COLLECT;
        else         r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps every path covered, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_xfer && r_cnt == LAST_BEAT) w_state_next = HOLD;
            HOLD:    if (w_pkg_hs) w_state_next = r_last_err ? DRAIN : COLLECT;
            DRAIN:   if (w_xfer && bus.s_axis_tlast) w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt       <= '0;
            r_pkg_valid <= 1'b0;
            r_last_err  <= 1'b0;
            r_short_err <= 1'b0;
            // NOTE: the wide package register is reset too, so no held data survives a reset.
            r_data      <= '0;
        end else begin
            r_short_err <= 1'b0;
            if (r_state == COLLECT && w_xfer) begin
                r_data[int'(r_cnt)*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] <= bus.s_axis_tdata;
                if (r_cnt == LAST_BEAT) begin
                    r_cnt       <= '0;
                    r_pkg_valid <= 1'b1;
                    r_last_err  <= ~bus.s_axis_tlast;
                end else if (bus.s_axis_tlast) begin
                    r_cnt       <= '0;
                    r_short_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (r_state == HOLD && w_pkg_hs) r_pkg_valid <= 1'b0;
        end
    end

    assign bus.s_axis_tready  = w_tready;
    assign bus.pkg_data_o     = r_data;
    assign bus.pkg_valid_o    = r_pkg_valid;
    assign bus.pkg_last_err_o = r_last_err;
    assign bus.short_err_o    = r_short_err;
endmodule

// File: tb/tb_axis_pkg_deserializer.sv
// Directed-plus-random bench: beats come from $urandom, the expected package is
// built by shifting each beat in from the top of a wide word.
module tb_axis_pkg_deserializer;
    localparam int W   = 32;
    localparam int NUM = 50;
    localparam int PW  = NUM * W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axis_pkg_deserializer_if #(.C_S_AXIS_TDATA_WIDTH(W), .PACKAGE_WIDTH(PW)) bus ();

    axis_pkg_deserializer #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .NUM(NUM),
        .PACKAGE_WIDTH(PW)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int short_seen  = 0;
    int pkg_seen    = 0;

    logic [W-1:0]  beats[NUM];
    logic [PW-1:0] exp_pkg;

    always @(posedge clk) begin
        if (bus.short_err_o) short_seen <= short_seen + 1;
        if (bus.pkg_valid_o && bus.pkg_ready_i) pkg_seen <= pkg_seen + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pkg(input string tag);
        int bad;
        vectors++;
        assert (bus.pkg_data_o === exp_pkg) else begin
            miscompares++;
            bad = 0;
            for (int i = NUM - 1; i >= 0; i--)
                if (bus.pkg_data_o[i*W +: W] !== exp_pkg[i*W +: W]) bad = i;
            $error("FAIL %s: beat %0d observed %h expected %h", tag, bad,
                   bus.pkg_data_o[bad*W +: W], exp_pkg[bad*W +: W]);
        end
    endtask

    task automatic gen_beats();
        for (int k = 0; k < NUM; k++) beats[k] = $urandom;
    endtask

    // Beat k shifted in from the top ends up at slice k once all NUM are in.
    task automatic build_expected();
        exp_pkg = '0;
        for (int k = 0; k < NUM; k++)
            exp_pkg = (exp_pkg >> W) | {beats[k], {(PW - W){1'b0}}};
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        bit acc;
        int n;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
        bus.s_axis_tstrb  = 4'($urandom);
        bus.s_axis_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_bit("beat_accept_timeout", acc, 1'b1);
        bus.s_axis_tvalid = 1'b0;
    endtask

    // Sends nb beats; tlast on index last_at; optional random idle cycles with junk data.
    task automatic send_pkg(input int nb, input int last_at, input bit gaps);
        logic [W-1:0] d;
        for (int k = 0; k < nb; k++) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                bus.s_axis_tvalid = 1'b0;
                bus.s_axis_tdata  = $urandom;
                bus.s_axis_tlast  = 1'($urandom_range(1, 0));
                tick();
            end
            d = (k < NUM) ? beats[k] : $urandom;
            send_beat(d, k == last_at);
        end
    endtask

    initial begin
        int base_pkg;
        int base_short;
        int stall;

        reset             = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tstrb  = '0;
        bus.pkg_ready_i   = 1'b0;
        repeat (3) tick();

        // Reset state
        exp_pkg = '0;
        check_bit("rst_valid", bus.pkg_valid_o, 1'b0);
        check_bit("rst_last_err", bus.pkg_last_err_o, 1'b0);
        check_bit("rst_short", bus.short_err_o, 1'b0);
        check_pkg("rst_data");
        reset = 1'b0;
        tick();
        check_bit("rst_release_tready", bus.s_axis_tready, 1'b1);

        // Counting pattern, consumer always ready
        bus.pkg_ready_i = 1'b1;
        for (int k = 0; k < NUM; k++) beats[k] = 32'h1000_0000 + W'(k);
        build_expected();
        send_pkg(NUM, NUM - 1, 1'b0);
        check_bit("cnt_valid", bus.pkg_valid_o, 1'b1);
        check_bit("cnt_tready_hold", bus.s_axis_tready, 1'b0);
        check_bit("cnt_last_err", bus.pkg_last_err_o, 1'b0);
        check_int("cnt_word0", int'(bus.pkg_data_o[31:0]), int'(32'h1000_0000));
        check_int("cnt_word49", int'(bus.pkg_data_o[PW-1 -: W]), int'(32'h1000_0031));
        check_pkg("cnt_data");
        tick();
        check_bit("cnt_valid_drop", bus.pkg_valid_o, 1'b0);
        check_bit("cnt_tready_back", bus.s_axis_tready, 1'b1);

        // Consumer stalls 10 cycles while the next package's first beat waits
        bus.pkg_ready_i = 1'b0;
        gen_beats();
        build_expected();
        send_pkg(NUM, NUM - 1, 1'b0);
        gen_beats();
        bus.s_axis_tdata  = beats[0];
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        base_pkg = pkg_seen;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_bit("stall_tready", bus.s_axis_tready, 1'b0);
            check_bit("stall_valid", bus.pkg_valid_o, 1'b1);
            check_bit("stall_last_err", bus.pkg_last_err_o, 1'b0);
            check_pkg("stall_data");
        end
        bus.pkg_ready_i = 1'b1;
        tick();
        check_int("stall_handshakes", pkg_seen, base_pkg + 1);
        check_bit("stall_valid_drop", bus.pkg_valid_o, 1'b0);
        build_expected();
        send_pkg(NUM, NUM - 1, 1'b0);
        check_bit("after_stall_valid", bus.pkg_valid_o, 1'b1);
        check_pkg("after_stall_data");
        tick();

        // Short package: tlast on beat 20
        base_pkg   = pkg_seen;
        base_short = short_seen;
        gen_beats();
        send_pkg(21, 20, 1'b0);
        check_bit("short_pulse", bus.short_err_o, 1'b1);
        check_bit("short_no_valid", bus.pkg_valid_o, 1'b0);
        tick();
        check_bit("short_pulse_end", bus.short_err_o, 1'b0);
        check_int("short_count", short_seen, base_short + 1);
        gen_beats();
        build_expected();
        send_pkg(NUM, NUM - 1, 1'b0);
        check_int("short_no_pkg", pkg_seen, base_pkg);
        check_bit("post_short_valid", bus.pkg_valid_o, 1'b1);
        check_pkg("post_short_data");
        tick();

        // Missing tlast on beat 49, three extra beats drained
        gen_beats();
        build_expected();
        send_pkg(NUM, -1, 1'b0);
        check_bit("long_valid", bus.pkg_valid_o, 1'b1);
        check_bit("long_last_err", bus.pkg_last_err_o, 1'b1);
        check_pkg("long_data");
        for (int e = 0; e < 3; e++) send_beat($urandom, e == 2);
        check_bit("drain_done_tready", bus.s_axis_tready, 1'b1);
        check_bit("drain_no_valid", bus.pkg_valid_o, 1'b0);
        check_pkg("drain_no_write");
        gen_beats();
        build_expected();
        send_pkg(NUM, NUM - 1, 1'b0);
        check_bit("post_drain_valid", bus.pkg_valid_o, 1'b1);
        check_bit("post_drain_last_err", bus.pkg_last_err_o, 1'b0);
        check_pkg("post_drain_data");
        tick();

        // Reset after beat 30
        base_short = short_seen;
        gen_beats();
        send_pkg(31, -1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pkg = '0;
        check_bit("midrst_valid", bus.pkg_valid_o, 1'b0);
        check_pkg("midrst_data");
        tick();
        check_bit("midrst_short", bus.short_err_o, 1'b0);
        check_int("midrst_short_count", short_seen, base_short);
        gen_beats();
        build_expected();
        send_pkg(NUM, NUM - 1, 1'b1);
        check_bit("gaps_valid", bus.pkg_valid_o, 1'b1);
        check_pkg("gaps_data");
        tick();
        send_pkg(NUM, NUM - 1, 1'b0);
        check_pkg("nogaps_same_data");
        tick();

        // Random packages with random consumer stalls
        for (int p = 0; p < 3; p++) begin
            bus.pkg_ready_i = 1'b0;
            gen_beats();
            build_expected();
            send_pkg(NUM, NUM - 1, 1'b1);
            check_bit("rand_valid", bus.pkg_valid_o, 1'b1);
            stall = $urandom_range(4, 0);
            repeat (stall) begin
                tick();
                check_pkg("rand_hold_data");
            end
            bus.pkg_ready_i = 1'b1;
            tick();
            check_bit("rand_valid_drop", bus.pkg_valid_o, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
